// File: rtl/ifmap_stream_tx_if.sv
// ----------------------------------------------------------------------------
// ifmap_stream_tx_if
// Tagged IFMap word stream between the feature-map reader and the Conv IFMap
// buffer.
//   IFMap         {tag[1:0], data}; tag[1] = start of row, tag[0] = end of row
//   IF_buff_wen   word valid (producer -> buffer)
//   IF_buff_ready buffer can accept (buffer -> producer)
// A word moves in a cycle where IF_buff_wen && IF_buff_ready.
// Modports: master = producer side, slave = Conv buffer side.
// ----------------------------------------------------------------------------
interface ifmap_stream_tx_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH+1:0] IFMap;
    logic                  IF_buff_wen;
    logic                  IF_buff_ready;

    modport master (
        output IFMap,
        output IF_buff_wen,
        input  IF_buff_ready
    );

    modport slave (
        input  IFMap,
        input  IF_buff_wen,
        output IF_buff_ready
    );
endinterface

// File: rtl/ifmap_stream_tx.sv
// ----------------------------------------------------------------------------
// ifmap_stream_tx
// Producer end of the Conv IFMap input stream. Reads num_rows rows of row_len
// feature-map words from a local SRAM, starting at base_addr and walking the
// address space linearly (wrapping), and streams them into the Conv IFMap
// buffer as {tag, data} words.
//
// Ports
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   start                     one-cycle launch pulse, honoured only when idle
//   base_addr/row_len/num_rows transfer shape, sampled on start
//   mem_ren, mem_addr         SRAM read request
//   mem_rdata                 SRAM read data, valid the cycle after mem_ren
//   ifm (master)              IFMap / IF_buff_wen / IF_buff_ready stream
//   busy                      high while running or signalling completion
//   done                      one-cycle pulse the cycle after the last word is
//                             accepted (or right after a zero-sized start)
//
// Build option
//   ROW_GAP_EN  when defined, one idle cycle is inserted on the stream after
//               every accepted end-of-row word; reads keep prefetching.
// ----------------------------------------------------------------------------
module ifmap_stream_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned ROWS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    ifmap_stream_tx_if.master     ifm,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  col_q;          // in-row position of the next read
    logic [ROWS_WIDTH-1:0] issue_rows_q;   // rows still to be read
    logic [ROWS_WIDTH-1:0] accept_rows_q;  // rows still to be accepted downstream

    logic                  inflight_q;     // read issued last cycle, data on mem_rdata now
    logic [1:0]            inflight_tag_q;

    logic [DATA_WIDTH+1:0] fifo_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic [DATA_WIDTH+1:0] head;
    logic                  wen;
    logic                  accept;
    logic                  row_last;
    logic [1:0]            tag_issue;
    logic [1:0]            pending;
    logic                  issue;
    logic                  last_accept;

`ifdef ROW_GAP_EN
    logic                  gap_q;
`endif

    always_comb begin
        head = fifo_q[rd_ptr_q];
`ifdef ROW_GAP_EN
        wen = (count_q != 2'd0) && !gap_q;
`else
        wen = (count_q != 2'd0);
`endif
        accept    = wen && ifm.IF_buff_ready;
        row_last  = (col_q == len_q - LEN_WIDTH'(1));
        tag_issue = {(col_q == '0), row_last};
        // The word leaving this cycle frees its slot already, which is what
        // lets a steady stream run at one word per cycle.
        pending = count_q - {1'b0, accept} + {1'b0, inflight_q};
        issue   = (state_q == RUN) && (issue_rows_q != '0) && (pending < 2'd2);
        last_accept = accept && head[DATA_WIDTH] && (accept_rows_q == ROWS_WIDTH'(1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((row_len == '0) || (num_rows == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            col_q          <= '0;
            issue_rows_q   <= '0;
            accept_rows_q  <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && start) begin
                addr_q        <= base_addr;
                len_q         <= row_len;
                col_q         <= '0;
                issue_rows_q  <= num_rows;
                accept_rows_q <= num_rows;
            end

            if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                if (row_last) begin
                    col_q        <= '0;
                    issue_rows_q <= issue_rows_q - ROWS_WIDTH'(1);
                end else begin
                    col_q <= col_q + LEN_WIDTH'(1);
                end
                inflight_tag_q <= tag_issue;
            end
            inflight_q <= issue;

            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= {inflight_tag_q, mem_rdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end

            if (accept) begin
                rd_ptr_q <= ~rd_ptr_q;
                if (head[DATA_WIDTH]) begin
                    accept_rows_q <= accept_rows_q - ROWS_WIDTH'(1);
                end
            end

            count_q <= count_q + {1'b0, inflight_q} - {1'b0, accept};
        end
    end

`ifdef ROW_GAP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= accept && head[DATA_WIDTH];
        end
    end
`endif

    assign mem_ren         = issue;
    assign mem_addr        = addr_q;
    assign ifm.IFMap       = head;
    assign ifm.IF_buff_wen = wen;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_ifmap_stream_tx.sv
`timescale 1ns/1ps
module tb_ifmap_stream_tx;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] row_len;
    logic [RW-1:0] num_rows;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    ifmap_stream_tx_if #(.DATA_WIDTH(DW)) ifm ();

    ifmap_stream_tx #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .ROWS_WIDTH(RW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .base_addr(base_addr),
        .row_len  (row_len),
        .num_rows (num_rows),
        .mem_ren  (mem_ren),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .ifm      (ifm),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int start_cyc;

    int vals[10] = '{88, 146, 78, -129, -123, -30, 68, -61, 28, -137};

    // SRAM model: one-cycle read latency
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= sram[mem_addr];
    end

    // Cycle counter and stream monitor (sampled on the falling edge)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW+1:0] acc_q[$];
    int            acc_cyc[$];
    logic [AW-1:0] ren_addr[$];
    int            ren_cyc[$];
    int            done_cnt   = 0;
    int            done_cyc   = 0;
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_word  = '0;

    always @(negedge clk) begin
        if (prev_stall && (!ifm.IF_buff_wen || ifm.IFMap !== prev_word))
            stall_viol <= stall_viol + 1;
        prev_stall <= rstn && ifm.IF_buff_wen && !ifm.IF_buff_ready;
        prev_word  <= ifm.IFMap;
        if (ifm.IF_buff_wen && ifm.IF_buff_ready) begin
            acc_q.push_back(ifm.IFMap);
            acc_cyc.push_back(cyc);
        end
        if (mem_ren) begin
            ren_addr.push_back(mem_addr);
            ren_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc.delete();
        ren_addr.delete();
        ren_cyc.delete();
    endtask

    task automatic load_vals();
        for (int i = 0; i < 10; i++) sram[i] = 16'(vals[i]);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l,
                            input logic [RW-1:0] r);
        base_addr = b;
        row_len   = l;
        num_rows  = r;
        start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base_cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != base_cnt) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        base_addr = '0;
        row_len = '0;
        num_rows = '0;
        ifm.IF_buff_ready = 1'b1;
        tick(2);
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("FAIL reset_mem_ren: got %b want 0", mem_ren); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        checks++; if (ifm.IFMap !== '0) begin failures++; $display("FAIL reset_ifmap: got %h want 0", ifm.IFMap); end
        checks++; if (ifm.IF_buff_wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b want 0", ifm.IF_buff_wen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        rstn = 1'b1;
        tick(2);
    endtask

    // Checks the ten-word sequence of the reference data, base 0
    task automatic check_ten(input string name);
        logic [1:0]    tag;
        logic [DW+1:0] exp;
        checks++;
        if (acc_q.size() != 10) begin
            failures++; $display("FAIL %s_count: got %0d want 10", name, acc_q.size());
        end
        checks++;
        if (ren_addr.size() != 10) begin
            failures++; $display("FAIL %s_reads: got %0d want 10", name, ren_addr.size());
        end
        for (int i = 0; i < 10; i++) begin
            tag = (i == 0) ? 2'b10 : ((i == 9) ? 2'b01 : 2'b00);
            exp = {tag, 16'(vals[i])};
            if (i < acc_q.size()) begin
                checks++;
                if (acc_q[i] !== exp) begin
                    failures++; $display("FAIL %s_word[%0d]: got %h want %h", name, i, acc_q[i], exp);
                end
            end
            if (i < ren_addr.size()) begin
                checks++;
                if (ren_addr[i] !== AW'(i)) begin
                    failures++; $display("FAIL %s_addr[%0d]: got %h want %h", name, i, ren_addr[i], AW'(i));
                end
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        int dbase;
        load_vals();
        ifm.IF_buff_ready = 1'b1;
        clear_logs();
        dbase = done_cnt;
        do_start(8'h00, 4'd10, 4'd1);
        wait_done(60, dbase, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got no done want done"); end
        check_ten("basic");
        if (acc_cyc.size() == 10 && ren_cyc.size() > 0) begin
            checks++;
            if (ren_cyc[0] != start_cyc + 1) begin
                failures++; $display("FAIL basic_ren_latency: got %0d want %0d", ren_cyc[0] - start_cyc, 1);
            end
            checks++;
            if (acc_cyc[0] != start_cyc + 3) begin
                failures++; $display("FAIL basic_wen_latency: got %0d want %0d", acc_cyc[0] - start_cyc, 3);
            end
            checks++;
            if (acc_cyc[9] - acc_cyc[0] != 9) begin
                failures++; $display("FAIL basic_throughput: got span %0d want 9", acc_cyc[9] - acc_cyc[0]);
            end
            checks++;
            if (done_cyc != acc_cyc[9] + 1) begin
                failures++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, acc_cyc[9] + 1);
            end
        end
        tick(3);
        checks++; if (done_cnt != dbase + 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - dbase); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int dbase;
        int sbase;
        load_vals();
        clear_logs();
        dbase = done_cnt;
        sbase = stall_viol;
        ifm.IF_buff_ready = 1'b1;
        do_start(8'h00, 4'd10, 4'd1);
        for (int k = 0; k < 200 && done_cnt == dbase; k++) begin
            ifm.IF_buff_ready = (k % 3 == 0);
            tick(1);
        end
        ifm.IF_buff_ready = 1'b1;
        checks++; if (done_cnt == dbase) begin failures++; $display("FAIL stall_timeout: got no done want done"); end
        check_ten("stall");
        checks++;
        if (stall_viol != sbase) begin
            failures++; $display("FAIL stall_stability: got %0d violations want 0", stall_viol - sbase);
        end
        tick(3);
    endtask

    task automatic test_wrap();
        bit ok;
        int dbase;
        logic [AW-1:0] exp_a [3];
        logic [DW-1:0] exp_d [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        exp_d[0] = 16'h1234; exp_d[1] = 16'h8001; exp_d[2] = 16'h7FFF;
        for (int i = 0; i < 3; i++) sram[exp_a[i]] = exp_d[i];
        ifm.IF_buff_ready = 1'b1;
        clear_logs();
        dbase = done_cnt;
        do_start(8'hFE, 4'd1, 4'd3);
        wait_done(40, dbase, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout: got no done want done"); end
        checks++; if (acc_q.size() != 3) begin failures++; $display("FAIL wrap_count: got %0d want 3", acc_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < acc_q.size()) begin
                checks++;
                if (acc_q[i] !== {2'b11, exp_d[i]}) begin
                    failures++; $display("FAIL wrap_word[%0d]: got %h want %h", i, acc_q[i], {2'b11, exp_d[i]});
                end
            end
            if (i < ren_addr.size()) begin
                checks++;
                if (ren_addr[i] !== exp_a[i]) begin
                    failures++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, ren_addr[i], exp_a[i]);
                end
            end
        end
        tick(3);
        load_vals();
    endtask

    task automatic test_zero_len();
        int dbase;
        for (int v = 0; v < 2; v++) begin
            clear_logs();
            dbase = done_cnt;
            if (v == 0) do_start(8'h10, 4'd0, 4'd3);
            else        do_start(8'h10, 4'd4, 4'd0);
            tick(5);
            checks++;
            if (done_cnt != dbase + 1) begin
                failures++; $display("FAIL zero%0d_done_pulses: got %0d want 1", v, done_cnt - dbase);
            end
            checks++;
            if (done_cyc != start_cyc + 1) begin
                failures++; $display("FAIL zero%0d_done_cycle: got %0d want %0d", v, done_cyc, start_cyc + 1);
            end
            checks++;
            if (ren_addr.size() != 0 || acc_q.size() != 0) begin
                failures++; $display("FAIL zero%0d_activity: got reads=%0d words=%0d want 0 0", v,
                                     ren_addr.size(), acc_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dbase;
        load_vals();
        ifm.IF_buff_ready = 1'b1;
        clear_logs();
        dbase = done_cnt;
        do_start(8'h00, 4'd10, 4'd1);
        for (int k = 0; k < 30 && acc_q.size() < 4; k++) tick(1);
        checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL mid_progress: got %0d words want 4", acc_q.size()); end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_ren !== 1'b0 || mem_addr !== '0 || ifm.IFMap !== '0 || ifm.IF_buff_wen !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got ren=%b addr=%h ifmap=%h wen=%b busy=%b done=%b want all 0",
                     mem_ren, mem_addr, ifm.IFMap, ifm.IF_buff_wen, busy, done);
        end
        tick(3);
        checks++; if (done_cnt != dbase) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - dbase); end
        rstn = 1'b1;
        tick(2);
        clear_logs();
        dbase = done_cnt;
        do_start(8'h00, 4'd10, 4'd1);
        wait_done(60, dbase, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_rerun_timeout: got no done want done"); end
        check_ten("mid_rerun");
        tick(3);
    endtask

    task automatic test_row_gap();
        bit ok;
        int dbase;
        int exp_gap;
        logic [1:0] exp_tag [6];
        exp_tag[0] = 2'b10; exp_tag[1] = 2'b00; exp_tag[2] = 2'b01;
        exp_tag[3] = 2'b10; exp_tag[4] = 2'b00; exp_tag[5] = 2'b01;
`ifdef ROW_GAP_EN
        exp_gap = 2;
`else
        exp_gap = 1;
`endif
        load_vals();
        ifm.IF_buff_ready = 1'b1;
        clear_logs();
        dbase = done_cnt;
        do_start(8'h00, 4'd3, 4'd2);
        wait_done(40, dbase, ok);
        checks++; if (!ok) begin failures++; $display("FAIL gap_timeout: got no done want done"); end
        checks++; if (acc_q.size() != 6) begin failures++; $display("FAIL gap_count: got %0d want 6", acc_q.size()); end
        for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== {exp_tag[i], 16'(vals[i])}) begin
                failures++; $display("FAIL gap_word[%0d]: got %h want %h", i, acc_q[i], {exp_tag[i], 16'(vals[i])});
            end
        end
        if (acc_cyc.size() == 6) begin
            checks++;
            if (acc_cyc[3] - acc_cyc[2] != exp_gap) begin
                failures++; $display("FAIL gap_between_rows: got %0d want %0d", acc_cyc[3] - acc_cyc[2], exp_gap);
            end
            checks++;
            if (acc_cyc[2] - acc_cyc[0] != 2 || acc_cyc[5] - acc_cyc[3] != 2) begin
                failures++; $display("FAIL gap_in_row: got %0d,%0d want 2,2",
                                     acc_cyc[2] - acc_cyc[0], acc_cyc[5] - acc_cyc[3]);
            end
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_row_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
